yin_tau_sequencer: RTL and testbench

YIN_TAU_SEQUENCER -- requirements
Module: yin_tau_sequencer

---
 rtl/yin_tau_sequencer_pkg.sv | 20 ++
 rtl/yin_tau_sequencer_if.sv | 26 ++
 rtl/yin_window_buffer.sv | 42 ++++
 rtl/yin_tau_sequencer.sv | 129 ++++++++++++
 tb/tb_yin_tau_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/yin_tau_sequencer_pkg.sv
// Shared types and default constants for the YIN tau sequencer slice.
package yin_tau_sequencer_pkg;

  localparam int DEF_WINDOW_SIZE_BITS        = 8;
  localparam int DEF_DATA_WIDTH              = 16;
  localparam int DEF_INTERMEDIATE_DATA_WIDTH = 32;
  localparam int DEF_MAX_TAU                 = 40;
  localparam int DEF_MIN_TAU                 = 2;

  typedef logic [5:0] tau_t;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/yin_tau_sequencer_if.sv
// Sample-in and result-out handshakes of the tau sequencer.
interface yin_tau_sequencer_if
  import yin_tau_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int INTERMEDIATE_DATA_WIDTH = DEF_INTERMEDIATE_DATA_WIDTH
);
  logic                               s_valid;
  logic                               s_ready;
  logic [DATA_WIDTH-1:0]              s_data;
  logic                               res_valid;
  logic                               res_ready;
  tau_t                               res_tau;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] res_value;

  // master is the sequencer side, slave is the producer/consumer around it
  modport master (
    input  s_valid, s_data, res_ready,
    output s_ready, res_valid, res_tau, res_value
  );

  modport slave (
    output s_valid, s_data, res_ready,
    input  s_ready, res_valid, res_tau, res_value
  );
endinterface

// File: rtl/yin_window_buffer.sv
// Sample window shift register with fill counter; slot 0 holds the oldest sample.
module yin_window_buffer #(
  parameter int DEPTH      = 296,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        shift_en,
  input  logic                        count_clr,
  input  logic [DATA_WIDTH-1:0]       s_data,
  output logic [DEPTH*DATA_WIDTH-1:0] window,
  output logic                        fill_done
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [DEPTH*DATA_WIDTH-1:0] window_q, window_d;
  logic [CNT_W-1:0]            count_q, count_d;

  assign fill_done = shift_en && (count_q == LAST);
  assign window    = window_q;

  always_comb begin
    window_d = window_q;
    count_d  = count_q;
    if (shift_en) begin
      window_d = {s_data, window_q[DEPTH*DATA_WIDTH-1:DATA_WIDTH]};
      count_d  = count_q + 1'b1;
    end
    if (count_clr || fill_done) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window_q <= '0;
      count_q  <= '0;
    end else begin
      window_q <= window_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/yin_tau_sequencer.sv
// YIN lag sweep controller: fills a window, steps tau through an external
// difference engine and reports the lag with the smallest sum. Optional early exit: YIN_EARLY_EXIT_EN.
module yin_tau_sequencer
  import yin_tau_sequencer_pkg::*;
#(
  parameter int WINDOW_SIZE_BITS        = DEF_WINDOW_SIZE_BITS,
  parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int INTERMEDIATE_DATA_WIDTH = DEF_INTERMEDIATE_DATA_WIDTH,
  parameter int MAX_TAU                 = DEF_MAX_TAU,
  parameter int MIN_TAU                 = DEF_MIN_TAU,
  parameter logic [INTERMEDIATE_DATA_WIDTH-1:0] THRESHOLD = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  yin_tau_sequencer_if.master          bus,
  output logic [(2**WINDOW_SIZE_BITS+MAX_TAU)*DATA_WIDTH-1:0] window_out,
  output tau_t                         tau_out,
  output logic                         diff_reset,
  input  logic                         diff_ready,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0] diff_acc
);
  localparam int DEPTH = 2**WINDOW_SIZE_BITS + MAX_TAU;

  state_e                             state_q, state_d;
  tau_t                               tau_q, tau_d;
  tau_t                               best_tau_q, best_tau_d;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] best_q, best_d;
  logic [INTERMEDIATE_DATA_WIDTH-1:0] acc_q, acc_d;
  logic                               wait_first_q, wait_first_d;
  logic                               fill_done;
  logic                               accept;

  assign bus.s_ready   = (state_q == FILL);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_tau   = best_tau_q;
  assign bus.res_value = best_q;
  assign diff_reset    = (state_q == START);
  assign tau_out       = tau_q;
  assign accept        = bus.s_valid && bus.s_ready;

  yin_window_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_window (
    .clk       (clk),
    .reset_n   (reset_n),
    .shift_en  (accept),
    .count_clr (bus.res_valid && bus.res_ready),
    .s_data    (bus.s_data),
    .window    (window_out),
    .fill_done (fill_done)
  );

`ifndef YIN_EARLY_EXIT_EN
  logic unused_threshold;
  assign unused_threshold = ^THRESHOLD;
`endif

  always_comb begin
    state_d      = state_q;
    tau_d        = tau_q;
    best_d       = best_q;
    best_tau_d   = best_tau_q;
    acc_d        = acc_q;
    wait_first_d = wait_first_q;
    unique case (state_q)
      FILL: begin
        if (fill_done) begin
          state_d = START;
          tau_d   = tau_t'(MIN_TAU);
          best_d  = '1;
        end
      end
      START: begin
        state_d      = WAIT;
        wait_first_d = 1'b1;
      end
      WAIT: begin
        // a ready left over from the previous lag must not be taken
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (diff_ready) begin
          acc_d   = diff_acc;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (acc_q < best_q) begin
          best_d     = acc_q;
          best_tau_d = tau_q;
        end
        if (tau_q == tau_t'(MAX_TAU)) begin
          state_d = DONE;
        end else begin
          tau_d   = tau_q + 1'b1;
          state_d = START;
        end
`ifdef YIN_EARLY_EXIT_EN
        if (acc_q < THRESHOLD) begin
          tau_d   = tau_q;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.res_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      tau_q        <= tau_t'(MIN_TAU);
      best_q       <= '0;
      best_tau_q   <= '0;
      acc_q        <= '0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tau_q        <= tau_d;
      best_q       <= best_d;
      best_tau_q   <= best_tau_d;
      acc_q        <= acc_d;
      wait_first_q <= wait_first_d;
    end
  end
endmodule

// File: tb/tb_yin_tau_sequencer.sv
// Directed bench for yin_tau_sequencer with a behavioural SSD engine of latency N.
module tb_yin_tau_sequencer;
  localparam int WSB   = 8;
  localparam int N     = 2**WSB;
  localparam int DW    = 16;
  localparam int IDW   = 32;
  localparam int MAXT  = 40;
  localparam int MINT  = 2;
  localparam int DEPTH = N + MAXT;
  localparam int PER_TAU = N + 3;
  localparam int LIMIT   = 12000;
`ifdef YIN_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [DEPTH*DW-1:0] window_out;
  logic [5:0]       tau_out;
  logic             diff_reset;
  logic             diff_ready;
  logic [IDW-1:0]   diff_acc;
  int               eng_cnt;

  int checks   = 0;
  int failures = 0;

  yin_tau_sequencer_if #(.DATA_WIDTH(DW), .INTERMEDIATE_DATA_WIDTH(IDW)) bus ();

  yin_tau_sequencer #(
    .WINDOW_SIZE_BITS        (WSB),
    .DATA_WIDTH              (DW),
    .INTERMEDIATE_DATA_WIDTH (IDW),
    .MAX_TAU                 (MAXT),
    .MIN_TAU                 (MINT),
    .THRESHOLD               (32'd1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .window_out (window_out),
    .tau_out    (tau_out),
    .diff_reset (diff_reset),
    .diff_ready (diff_ready),
    .diff_acc   (diff_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IDW-1:0] ssd(input int tau);
    longint s = 0;
    for (int j = 0; j < N; j++) begin
      longint d = longint'(window_out[j*DW +: DW]) - longint'(window_out[(j+tau)*DW +: DW]);
      s += d * d;
    end
    return s[IDW-1:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_cnt    <= 0;
      diff_ready <= 1'b0;
      diff_acc   <= '0;
    end else if (diff_reset) begin
      eng_cnt    <= N;
      diff_ready <= 1'b0;
      diff_acc   <= ssd(int'(tau_out));
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) diff_ready <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] sample(input int kind, input int i);
    case (kind)
      0:       return ((i / 10) % 2) != 0 ? 16'd1000 : 16'd0;
      1:       return 16'd500;
      default: return ((i / 8) % 2) != 0 ? 16'd1000 : 16'd0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int window_mismatches(input int kind);
    int bad = 0;
    for (int k = 0; k < DEPTH; k++)
      if (window_out[k*DW +: DW] !== sample(kind, k)) bad++;
    return bad;
  endfunction

  function automatic int window_nonzero();
    int bad = 0;
    for (int k = 0; k < DEPTH; k++)
      if (window_out[k*DW +: DW] !== '0) bad++;
    return bad;
  endfunction

  task automatic fill(input int kind, input bit toggle);
    int bad = 0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (toggle) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
        if (diff_reset || !bus.s_ready) bad++;
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = sample(kind, i);
      @(negedge clk);
      if (diff_reset || !bus.s_ready) bad++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    check_eq("fill_no_early_start", bad, 0);
    @(negedge clk);
    check_eq("start_after_last_accept", {62'd0, bus.s_ready, diff_reset}, 64'd1);
  endtask

  task automatic run_sweep(input bit poke, output int cycles, output int hi);
    cycles = -1;
    hi = 0;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (poke) bus.res_ready = (n == 5);
      if (diff_reset && tau_out > 6'd20) hi++;
      if (bus.res_valid) begin
        cycles = n;
        break;
      end
    end
    bus.res_ready = 1'b0;
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check_eq("hs_s_ready", bus.s_ready, 1);
    check_eq("hs_res_valid", bus.res_valid, 0);
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_s_ready"}, bus.s_ready, 1);
    check_eq({pfx, "_diff_reset"}, diff_reset, 0);
    check_eq({pfx, "_res_valid"}, bus.res_valid, 0);
    check_eq({pfx, "_res_tau"}, bus.res_tau, 0);
    check_eq({pfx, "_res_value"}, bus.res_value, 0);
    check_eq({pfx, "_tau_out"}, tau_out, MINT);
    check_eq({pfx, "_window_zero"}, window_nonzero(), 0);
  endtask

  initial begin
    int cyc, hi, bad, n_found;
    reset_n       = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.res_ready = 1'b0;
    #12;
    check_reset_state("rst");
    reset_n = 1'b1;

    // frame 1: period-20 square wave, back-to-back fill
    fill(0, 1'b0);
    run_sweep(1'b0, cyc, hi);
    check_eq("sq20_res_tau", bus.res_tau, 20);
    check_eq("sq20_res_value", bus.res_value, 0);
    check_eq("sq20_sweep_cycles", cyc, EE ? (20 - MINT + 1) * PER_TAU : (MAXT - MINT + 1) * PER_TAU);
    check_eq("sq20_starts_above_20", hi, EE ? 0 : MAXT - 20);
    check_eq("sq20_window_order", window_mismatches(0), 0);
    handshake();

    // frame 2: constant input, stray res_ready mid-sweep, then long DONE hold
    fill(1, 1'b0);
    run_sweep(1'b1, cyc, hi);
    check_eq("const_res_tau", bus.res_tau, MINT);
    check_eq("const_res_value", bus.res_value, 0);
    check_eq("const_sweep_cycles", cyc, EE ? PER_TAU : (MAXT - MINT + 1) * PER_TAU);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd7;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_tau != 6'(MINT) || bus.res_value != '0 || bus.s_ready) bad++;
    end
    bus.s_valid = 1'b0;
    check_eq("hold_bad_cycles", bad, 0);
    check_eq("hold_window_frozen", window_mismatches(1), 0);
    handshake();

    // frame 3: reset while waiting on the engine at tau 17
    fill(0, 1'b0);
    n_found = 0;
    for (int n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (diff_reset && tau_out == 6'd17) begin
        n_found = 1;
        break;
      end
    end
    check_eq("found_tau17", n_found, 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    reset_n = 1'b1;

    // frame 4: period-16 wave with s_valid toggling every other cycle
    fill(2, 1'b1);
    run_sweep(1'b0, cyc, hi);
    check_eq("sq16_res_tau", bus.res_tau, 16);
    check_eq("sq16_res_value", bus.res_value, 0);
    check_eq("sq16_sweep_cycles", cyc, EE ? (16 - MINT + 1) * PER_TAU : (MAXT - MINT + 1) * PER_TAU);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
